// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared opcode constants, FSM states and class struct for hazard_ctrl
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } iclass_t;

endpackage

// File: rtl/hazard_ctrl_instr_class.sv
// rtl/hazard_ctrl_instr_class.sv - opcode to register-usage classification
module instr_class
    import hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd
);

    iclass_t cls;

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R:      cls = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
            OP_I_ALU:  cls = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_LOAD:   cls = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_STORE:  cls = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
            OP_BRANCH: cls = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
            OP_JALR:   cls = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_JAL:    cls = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_LUI:    cls = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_AUIPC:  cls = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            default:   cls = '0;
        endcase
    end

    assign uses_rs1  = cls.uses_rs1;
    assign uses_rs2  = cls.uses_rs2;
    assign writes_rd = cls.writes_rd;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - scoreboard RAW stall and branch flush controller for the decode stage
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          WB_BYPASS    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_branch_taken,
    input  logic        wb_write_enable,
    input  logic [4:0]  wb_write_addr,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_id,
    output logic        flush_if,
    output logic [31:0] stall_cycles,
    output logic        sb_error
);

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    logic [4:0] rd, rs1, rs2;
    logic       uses_rs1, uses_rs2, writes_rd;
    logic [1:0] cnt [32];
    logic       hz1, hz2, raw_hazard, flush, stall;
    logic       do_inc, do_dec, same, ovf, udf;
    hz_state_t  state, state_next;
    logic [2:0] fcnt, fcnt_next;
    logic       unused_funct;

    assign rd  = id_instr[11:7];
    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign unused_funct = ^{id_instr[31:25], id_instr[14:12]};

    instr_class u_class (
        .opcode    (id_instr[6:0]),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd)
    );

    // A retiring write with count 1 is invisible when the regfile forwards same-edge writes.
    always_comb begin
        hz1 = (rs1 != 5'd0) && (cnt[rs1] != 2'd0);
        hz2 = (rs2 != 5'd0) && (cnt[rs2] != 2'd0);
        if (WB_BYPASS && wb_write_enable && wb_write_addr == rs1 && cnt[rs1] == 2'd1)
            hz1 = 1'b0;
        if (WB_BYPASS && wb_write_enable && wb_write_addr == rs2 && cnt[rs2] == 2'd1)
            hz2 = 1'b0;
    end

    assign raw_hazard = id_valid & ((hz1 & uses_rs1) | (hz2 & uses_rs2));

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        case (state)
            ST_RUN: begin
                if (ex_branch_taken && FLUSH_CYCLES != 0) begin
                    state_next = ST_FLUSH;
                    fcnt_next  = FC;
                end
            end
            ST_FLUSH: begin
                if (ex_branch_taken) begin
                    fcnt_next = FC;
                end else if (fcnt == 3'd1) begin
                    state_next = ST_RUN;
                    fcnt_next  = 3'd0;
                end else begin
                    fcnt_next = fcnt - 3'd1;
                end
            end
            default: begin
                state_next = ST_RUN;
                fcnt_next  = 3'd0;
            end
        endcase
        // Reset is folded into flush so nothing issues or stalls while rst is held.
        flush     = rst | ex_branch_taken | (state == ST_FLUSH);
        stall     = raw_hazard & ~flush;
        stall_if  = stall;
        stall_id  = stall;
        bubble_id = raw_hazard | flush | ~id_valid;
        flush_if  = flush;
    end

    assign do_inc = id_valid & ~raw_hazard & ~flush & writes_rd & (rd != 5'd0);
    assign do_dec = wb_write_enable & (wb_write_addr != 5'd0);
    assign same   = do_inc & do_dec & (rd == wb_write_addr);
    assign ovf    = do_inc & ~same & (cnt[rd] == 2'd3);
    assign udf    = do_dec & ~same & (cnt[wb_write_addr] == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
            state        <= ST_RUN;
            fcnt         <= 3'd0;
            stall_cycles <= 32'd0;
            sb_error     <= 1'b0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
            if (stall) stall_cycles <= stall_cycles + 32'd1;
            if (ovf | udf) sb_error <= 1'b1;
            for (int r = 1; r < 32; r++) begin
                if (do_inc && !same && rd == 5'(r) && cnt[r] != 2'd3)
                    cnt[r] <= cnt[r] + 2'd1;
                else if (do_dec && !same && wb_write_addr == 5'(r) && cnt[r] != 2'd0)
                    cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid, ex_branch_taken, wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic        stall_if, stall_id, bubble_id, flush_if, sb_error;
    logic [31:0] stall_cycles;

    logic [31:0] b_id_instr;
    logic        b_id_valid, b_ex_branch_taken, b_wb_write_enable;
    logic [4:0]  b_wb_write_addr;
    logic        b_stall_if, b_stall_id, b_bubble_id, b_flush_if, b_sb_error;
    logic [31:0] b_stall_cycles;

    integer total = 0;
    integer bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .WB_BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .ex_branch_taken(ex_branch_taken), .wb_write_enable(wb_write_enable),
        .wb_write_addr(wb_write_addr), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_id(bubble_id), .flush_if(flush_if), .stall_cycles(stall_cycles),
        .sb_error(sb_error)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .WB_BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst(rst), .id_instr(b_id_instr), .id_valid(b_id_valid),
        .ex_branch_taken(b_ex_branch_taken), .wb_write_enable(b_wb_write_enable),
        .wb_write_addr(b_wb_write_addr), .stall_if(b_stall_if), .stall_id(b_stall_id),
        .bubble_id(b_bubble_id), .flush_if(b_flush_if), .stall_cycles(b_stall_cycles),
        .sb_error(b_sb_error)
    );

    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b_id_valid = 1'b0; b_ex_branch_taken = 1'b0; b_wb_write_enable = 1'b0;
        b_wb_write_addr = 5'd0; b_id_instr = 32'd0;
        for (int c = 0; c < 2; c++) begin
            id_instr = $urandom; id_valid = 1'($urandom); ex_branch_taken = 1'($urandom);
            wb_write_enable = 1'($urandom); wb_write_addr = 5'($urandom);
            #1;
            total++; if (bubble_id !== 1'b1) begin bad++; $display("FAIL rst_bubble got=%b exp=1", bubble_id); end
            total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL rst_flush_if got=%b exp=1", flush_if); end
            total++; if (stall_if !== 1'b0 || stall_id !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b%b exp=00", stall_if, stall_id); end
            tick();
            total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_stall_cycles got=%0d exp=0", stall_cycles); end
            total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL rst_sb_error got=%b exp=0", sb_error); end
            total++; if (b_stall_cycles !== 32'd0 || b_sb_error !== 1'b0) begin bad++; $display("FAIL rst_bp got=%0d/%b exp=0/0", b_stall_cycles, b_sb_error); end
        end
        rst = 1'b0; id_valid = 1'b0; ex_branch_taken = 1'b0; wb_write_enable = 1'b0;
        wb_write_addr = 5'd0;
        tick();
        for (int r = 1; r < 32; r++) begin
            id_instr = f_add(5'd0, 5'(r), 5'(r)); id_valid = 1'b1;
            #1;
            total++; if (stall_if !== 1'b0 || bubble_id !== 1'b0) begin bad++; $display("FAIL rst_cnt_zero x%0d stall=%b bubble=%b exp=0/0", r, stall_if, bubble_id); end
            tick();
        end
        id_valid = 1'b0;
        tick();
    endtask

    task automatic test_raw_stall();
        id_instr = f_addi(5'd5, 5'd0); id_valid = 1'b1;
        #1;
        total++; if (stall_if !== 1'b0 || bubble_id !== 1'b0) begin bad++; $display("FAIL raw_issue stall=%b bubble=%b exp=0/0", stall_if, bubble_id); end
        tick();
        id_instr = f_add(5'd6, 5'd5, 5'd5);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin wb_write_enable = 1'b1; wb_write_addr = 5'd5; end
            #1;
            total++; if ({stall_if, stall_id, bubble_id, flush_if} !== 4'b1110) begin bad++; $display("FAIL raw_stall c%0d got=%b exp=1110", c, {stall_if, stall_id, bubble_id, flush_if}); end
            tick();
        end
        wb_write_enable = 1'b0;
        #1;
        total++; if (stall_if !== 1'b0 || bubble_id !== 1'b0) begin bad++; $display("FAIL raw_release stall=%b bubble=%b exp=0/0", stall_if, bubble_id); end
        tick();
        total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL raw_stall_cycles got=%0d exp=3", stall_cycles); end
        id_valid = 1'b0; wb_write_enable = 1'b1; wb_write_addr = 5'd6;
        tick();
        wb_write_enable = 1'b0;
        total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL raw_sb_error got=%b exp=0", sb_error); end
    endtask

    task automatic test_wb_bypass();
        b_id_instr = f_addi(5'd5, 5'd0); b_id_valid = 1'b1;
        tick();
        b_id_instr = f_add(5'd6, 5'd5, 5'd5);
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (b_stall_if !== 1'b1 || b_bubble_id !== 1'b1) begin bad++; $display("FAIL bp_stall c%0d stall=%b bubble=%b exp=1/1", c, b_stall_if, b_bubble_id); end
            tick();
        end
        b_wb_write_enable = 1'b1; b_wb_write_addr = 5'd5;
        #1;
        total++; if (b_stall_if !== 1'b0 || b_bubble_id !== 1'b0) begin bad++; $display("FAIL bp_release stall=%b bubble=%b exp=0/0", b_stall_if, b_bubble_id); end
        tick();
        total++; if (b_stall_cycles !== 32'd2) begin bad++; $display("FAIL bp_stall_cycles got=%0d exp=2", b_stall_cycles); end
        b_id_valid = 1'b0; b_wb_write_addr = 5'd6;
        tick();
        b_wb_write_enable = 1'b0;
        total++; if (b_sb_error !== 1'b0) begin bad++; $display("FAIL bp_sb_error got=%b exp=0", b_sb_error); end
    endtask

    task automatic test_branch_flush();
        id_instr = f_addi(5'd5, 5'd0); id_valid = 1'b1;
        tick();
        id_instr = f_addi(5'd7, 5'd5); ex_branch_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if ({flush_if, bubble_id, stall_if} !== 3'b110) begin bad++; $display("FAIL br_flush c%0d got=%b exp=110", c, {flush_if, bubble_id, stall_if}); end
            tick();
            ex_branch_taken = 1'b0;
        end
        wb_write_enable = 1'b1; wb_write_addr = 5'd5;
        #1;
        total++; if ({flush_if, stall_if} !== 2'b01) begin bad++; $display("FAIL br_after got=%b exp=01", {flush_if, stall_if}); end
        tick();
        wb_write_enable = 1'b0; id_instr = f_add(5'd0, 5'd7, 5'd7);
        #1;
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL br_cnt7 stall=%b exp=0", stall_if); end
        tick();
        id_valid = 1'b0;
        total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL br_stall_cycles got=%0d exp=4", stall_cycles); end
    endtask

    task automatic test_x0_same_edge();
        id_instr = f_addi(5'd0, 5'd0); id_valid = 1'b1;
        tick();
        id_instr = f_addi(5'd9, 5'd0);
        tick();
        wb_write_enable = 1'b1; wb_write_addr = 5'd9;
        #1;
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL same_issue stall=%b exp=0", stall_if); end
        tick();
        id_instr = f_add(5'd0, 5'd9, 5'd9);
        #1;
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL same_cnt_one stall=%b exp=1", stall_if); end
        tick();
        wb_write_enable = 1'b0;
        #1;
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL same_drained stall=%b exp=0", stall_if); end
        tick();
        id_valid = 1'b0;
        total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL same_sb_error got=%b exp=0", sb_error); end
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL same_stall_cycles got=%0d exp=5", stall_cycles); end
    endtask

    task automatic test_errors();
        id_instr = f_addi(5'd3, 5'd0); id_valid = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        total++; if (sb_error !== 1'b1) begin bad++; $display("FAIL err_overflow got=%b exp=1", sb_error); end
        id_instr = f_add(5'd0, 5'd3, 5'd3);
        wb_write_enable = 1'b1; wb_write_addr = 5'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL err_sat c%0d stall=%b exp=1", c, stall_if); end
            tick();
        end
        wb_write_enable = 1'b0;
        #1;
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL err_sat_drained stall=%b exp=0", stall_if); end
        tick();
        id_valid = 1'b0;
        total++; if (stall_cycles !== 32'd8) begin bad++; $display("FAIL err_stall_cycles got=%0d exp=8", stall_cycles); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL err_rst_clear got=%b exp=0", sb_error); end
        wb_write_enable = 1'b1; wb_write_addr = 5'd4;
        tick();
        wb_write_enable = 1'b0;
        total++; if (sb_error !== 1'b1) begin bad++; $display("FAIL err_underflow got=%b exp=1", sb_error); end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_wb_bypass();
        test_branch_flush();
        test_x0_same_edge();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
